// File: rtl/rvvi_ack_packetizer_pkg.sv
// Shared configuration type and frame word-offset constants for the RVVI
// ack packetizer and its receive-side counterpart.
package rvvi_ack_packetizer_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 32'd64};

    localparam int unsigned RVVI_ETH_HDR_WORDS     = 3;
    localparam int unsigned RVVI_ACK_PAYLOAD_WORDS = 4;
    localparam int unsigned RVVI_ACK_BUF_WORDS     = RVVI_ETH_HDR_WORDS + RVVI_ACK_PAYLOAD_WORDS;

    localparam logic [3:0] RVVI_AXI_STRB_ALL = 4'hF;

endpackage

// File: rtl/rvvi_ack_packetizer_if.sv
// 32-bit AXI-stream write channel between the packetizer and the MAC TX port.
interface rvvi_ack_packetizer_if;

    logic [31:0] RvviAxiWdata;
    logic [3:0]  RvviAxiWstrb;
    logic        RvviAxiWlast;
    logic        RvviAxiWvalid;
    logic        RvviAxiWready;

    modport master (
        output RvviAxiWdata,
        output RvviAxiWstrb,
        output RvviAxiWlast,
        output RvviAxiWvalid,
        input  RvviAxiWready
    );

    modport slave (
        input  RvviAxiWdata,
        input  RvviAxiWstrb,
        input  RvviAxiWlast,
        input  RvviAxiWvalid,
        output RvviAxiWready
    );

endinterface

// File: rtl/rvvi_ack_packetizer_counter.sv
// Free-running up-counter with synchronous clear and count enable.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= q + WIDTH'(1);
    end

endmodule

// File: rtl/rvvi_ack_packetizer.sv
// Builds the Minstret/inter-packet-delay Ethernet frame and streams it as
// 32-bit AXI-stream beats, followed by an enforced inter-frame gap.
module rvvi_ack_packetizer
    import rvvi_ack_packetizer_pkg::*;
#(
    parameter cvw_t P           = CVW_DEFAULT,
    parameter int   FRAME_WORDS = 15,
    parameter int   IFG_CYCLES  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Send,
    input  logic [P.XLEN-1:0]     Minstr,
    input  logic [31:0]           InterPacketDelay,
    input  logic [47:0]           DstMac,
    input  logic [47:0]           SrcMac,
    input  logic [15:0]           EthType,
    rvvi_ack_packetizer_if.master axi,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Dropped
);

    typedef enum logic [1:0] {STATE_IDLE, STATE_SEND, STATE_GAP} statetype;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_WORDS - 1);
    localparam logic [7:0] GAP_LOAD = 8'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    statetype    state, nextstate;
    logic [7:0]  idx;
    logic [7:0]  gapcnt;
    logic [31:0] wbuf [RVVI_ACK_BUF_WORDS];
    logic [31:0] word;
    logic [63:0] m64;
    logic        capture, beat, lastidx, idxreset, idxen;

    assign m64     = 64'(Minstr);
    assign beat    = (state == STATE_SEND) && axi.RvviAxiWready;
    assign lastidx = (idx == LAST_IDX);
    assign Dropped = Send && (state != STATE_IDLE);

    // Index is held at zero outside SEND so every frame starts at word 0.
    assign idxreset = reset || (state != STATE_SEND);
    assign idxen    = beat && !lastidx;

    counter #(.WIDTH(8)) idxcounter (
        .clk   (clk),
        .reset (idxreset),
        .en    (idxen),
        .q     (idx)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= STATE_IDLE;
        else       state <= nextstate;
    end

    always_comb begin
        nextstate         = state;
        capture           = 1'b0;
        Busy              = 1'b0;
        axi.RvviAxiWvalid = 1'b0;
        axi.RvviAxiWdata  = '0;
        axi.RvviAxiWstrb  = '0;
        axi.RvviAxiWlast  = 1'b0;
        case (state)
            STATE_IDLE: begin
                if (Send) begin
                    capture   = 1'b1;
                    nextstate = STATE_SEND;
                end
            end
            STATE_SEND: begin
                Busy              = 1'b1;
                axi.RvviAxiWvalid = 1'b1;
                axi.RvviAxiWdata  = word;
                axi.RvviAxiWstrb  = RVVI_AXI_STRB_ALL;
                axi.RvviAxiWlast  = lastidx;
                if (beat && lastidx)
                    nextstate = (IFG_CYCLES > 0) ? STATE_GAP : STATE_IDLE;
            end
            STATE_GAP: begin
                Busy = 1'b1;
                if (gapcnt == '0) nextstate = STATE_IDLE;
            end
            default: nextstate = STATE_IDLE;
        endcase
    end

    always_comb begin
        word = '0;
        if (idx < 8'(RVVI_ACK_BUF_WORDS)) word = wbuf[idx[2:0]];
    end

    // The whole frame is snapshotted at Send so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RVVI_ACK_BUF_WORDS; i++) wbuf[i] <= '0;
        end else if (capture) begin
            wbuf[0] <= DstMac[31:0];
            wbuf[1] <= {SrcMac[15:0], DstMac[47:32]};
            wbuf[2] <= SrcMac[47:16];
            wbuf[3] <= {m64[15:0], EthType};
            wbuf[4] <= m64[47:16];
            wbuf[5] <= {InterPacketDelay[15:0], m64[63:48]};
            wbuf[6] <= {16'h0, InterPacketDelay[31:16]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                        gapcnt <= '0;
        else if (beat && lastidx)         gapcnt <= GAP_LOAD;
        else if (state == STATE_GAP && gapcnt != '0) gapcnt <= gapcnt - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) Done <= 1'b0;
        else       Done <= beat && lastidx;
    end

endmodule

// File: tb/tb_rvvi_ack_packetizer.sv
// Scoreboard bench for rvvi_ack_packetizer: expected beats are queued at Send
// and checked as the stream handshakes.
module tb_rvvi_ack_packetizer;
    import rvvi_ack_packetizer_pkg::*;

    localparam int FW  = 15;
    localparam int IFG = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        Send;
    logic [63:0] Minstr;
    logic [31:0] Ipd;
    logic [47:0] DstMac, SrcMac;
    logic [15:0] EthType;
    logic        Busy, Done, Dropped;

    rvvi_ack_packetizer_if bus();

    rvvi_ack_packetizer #(.P(CVW_DEFAULT), .FRAME_WORDS(FW), .IFG_CYCLES(IFG)) dut (
        .clk              (clk),
        .reset            (reset),
        .Send             (Send),
        .Minstr           (Minstr),
        .InterPacketDelay (Ipd),
        .DstMac           (DstMac),
        .SrcMac           (SrcMac),
        .EthType          (EthType),
        .axi              (bus),
        .Busy             (Busy),
        .Done             (Done),
        .Dropped          (Dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [36:0] exp_q[$];
    int          hs_count = 0;
    int          last_hs_cyc = -1;
    bit          stalled = 0;
    logic [36:0] held;

    function automatic logic [31:0] exp_word(int i);
        logic [63:0] m;
        m = Minstr;
        case (i)
            0:       return DstMac[31:0];
            1:       return {SrcMac[15:0], DstMac[47:32]};
            2:       return SrcMac[47:16];
            3:       return {m[15:0], EthType};
            4:       return m[47:16];
            5:       return {Ipd[15:0], m[63:48]};
            6:       return {16'h0, Ipd[31:16]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic push_frame();
        for (int i = 0; i < FW; i++)
            exp_q.push_back({(i == FW - 1), 4'hF, exp_word(i)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            tick();
            if (Done === 1'b1) seen = 1;
        end
    endtask

    // Stream monitor: pops the scoreboard on every handshake and checks hold during stalls.
    always @(negedge clk) begin
        logic [36:0] obs;
        logic [36:0] e;
        obs = {bus.RvviAxiWlast, bus.RvviAxiWstrb, bus.RvviAxiWdata};
        if (reset !== 1'b0) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                checks++;
                if (bus.RvviAxiWvalid !== 1'b1 || obs !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, expected valid=1 beat=%h",
                             bus.RvviAxiWvalid, obs, held);
                end
            end
            stalled = 0;
            if (bus.RvviAxiWvalid === 1'b1) begin
                if (bus.RvviAxiWready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_extra: got beat=%h, expected no beat", obs);
                    end else begin
                        e = exp_q.pop_front();
                        if (obs !== e) begin
                            errors++;
                            $display("FAIL beat_word: got {last,strb,data}=%h, expected %h", obs, e);
                        end
                    end
                    hs_count++;
                    if (bus.RvviAxiWlast === 1'b1) last_hs_cyc = cyc + 1;
                end else begin
                    stalled = 1;
                    held    = obs;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        Send  = 1'b0;
        bus.RvviAxiWready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.RvviAxiWvalid, bus.RvviAxiWlast, bus.RvviAxiWstrb, bus.RvviAxiWdata} !== 38'h0) begin
            errors++;
            $display("FAIL reset_stream: got valid=%b last=%b strb=%h data=%h, expected all 0",
                     bus.RvviAxiWvalid, bus.RvviAxiWlast, bus.RvviAxiWstrb, bus.RvviAxiWdata);
        end
        checks++;
        if ({Busy, Done, Dropped} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got busy/done/dropped=%b, expected 000", {Busy, Done, Dropped});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({Busy, Done, Dropped, bus.RvviAxiWvalid} !== 4'b0000 || bus.RvviAxiWdata !== 32'h0) begin
            errors++;
            $display("FAIL idle_outputs: got busy/done/dropped/valid=%b data=%h, expected 0000 and 0",
                     {Busy, Done, Dropped, bus.RvviAxiWvalid}, bus.RvviAxiWdata);
        end
    endtask

    task automatic test_basic();
        bit seen;
        int hs0;
        DstMac  = 48'h1122_3344_5566;
        SrcMac  = 48'hA1A2_A3A4_A5A6;
        EthType = 16'h88B5;
        Minstr  = 64'h0123_4567_89AB_CDEF;
        Ipd     = 32'hDEAD_BEEF;
        bus.RvviAxiWready = 1'b1;
        hs0 = hs_count;
        Send = 1'b1;
        push_frame();
        #1;
        checks++;
        if (Dropped !== 1'b0) begin
            errors++;
            $display("FAIL idle_send_dropped: got %b, expected 0", Dropped);
        end
        tick();
        Send = 1'b0;
        checks++;
        if (bus.RvviAxiWvalid !== 1'b1 || bus.RvviAxiWdata !== 32'h3344_5566) begin
            errors++;
            $display("FAIL first_beat_latency: got valid=%b data=%h, expected valid=1 data=33445566",
                     bus.RvviAxiWvalid, bus.RvviAxiWdata);
        end
        wait_done(40, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL basic_done: got no Done within 40 cycles, expected Done");
        end
        checks++;
        if (cyc != last_hs_cyc) begin
            errors++;
            $display("FAIL done_timing: got Done at cycle %0d, expected cycle %0d", cyc, last_hs_cyc);
        end
        checks++;
        if (hs_count - hs0 != FW || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count: got %0d handshakes (%0d left), expected %0d (0 left)",
                     hs_count - hs0, exp_q.size(), FW);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse_gap: got done=%b busy=%b, expected done=0 busy=1", Done, Busy);
        end
        repeat (IFG) tick();
    endtask

    task automatic test_stall();
        bit seen;
        int hs0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        DstMac  = 48'hFEDC_BA98_7654;
        SrcMac  = 48'h0246_8ACE_1357;
        EthType = 16'h1234;
        Minstr  = 64'h8000_0000_0000_0001;
        Ipd     = 32'h0BAD_F00D;
        hs0  = hs_count;
        Send = 1'b1;
        push_frame();
        tick();
        Send = 1'b0;
        seen = 0;
        for (int c = 0; c < 120 && !seen; c++) begin
            bus.RvviAxiWready = pat[c % 4];
            tick();
            if (Done === 1'b1) seen = 1;
        end
        bus.RvviAxiWready = 1'b1;
        checks++;
        if (!seen || hs_count - hs0 != FW || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_frame: got done=%b handshakes=%0d left=%0d, expected done=1 handshakes=%0d left=0",
                     seen, hs_count - hs0, exp_q.size(), FW);
        end
        repeat (IFG + 1) tick();
    endtask

    task automatic test_drop();
        bit seen;
        Minstr = 64'h0000_0000_CAFE_0042;
        Ipd    = 32'h0000_0100;
        bus.RvviAxiWready = 1'b1;
        Send = 1'b1;
        push_frame();
        tick();
        Send = 1'b0;
        repeat (3) tick();
        Send = 1'b1;
        #1;
        checks++;
        if (Dropped !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_in_send: got dropped=%b busy=%b, expected 1 1", Dropped, Busy);
        end
        tick();
        Send = 1'b0;
        wait_done(40, seen);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drop_frame: got done=%b left=%0d, expected done=1 left=0", seen, exp_q.size());
        end
        Send = 1'b1;
        #1;
        checks++;
        if (Dropped !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_in_gap: got dropped=%b busy=%b, expected 1 1", Dropped, Busy);
        end
        tick();
        Send = 1'b0;
        for (int g = 1; g < IFG; g++) begin
            checks++;
            if (Busy !== 1'b1) begin
                errors++;
                $display("FAIL gap_busy_%0d: got busy=%b, expected 1", g, Busy);
            end
            tick();
        end
        checks++;
        if (Busy !== 1'b0 || bus.RvviAxiWvalid !== 1'b0) begin
            errors++;
            $display("FAIL gap_end: got busy=%b valid=%b, expected 0 0", Busy, bus.RvviAxiWvalid);
        end
        Send = 1'b1;
        push_frame();
        #1;
        checks++;
        if (Dropped !== 1'b0) begin
            errors++;
            $display("FAIL first_idle_send: got dropped=%b, expected 0", Dropped);
        end
        tick();
        Send = 1'b0;
        checks++;
        if (bus.RvviAxiWvalid !== 1'b1) begin
            errors++;
            $display("FAIL first_idle_accept: got valid=%b, expected 1", bus.RvviAxiWvalid);
        end
        for (int c = 0; c < 40 && !(bus.RvviAxiWvalid === 1'b1 && bus.RvviAxiWlast === 1'b1); c++) tick();
        Send = 1'b1;
        #1;
        checks++;
        if (Dropped !== 1'b1 || bus.RvviAxiWlast !== 1'b1) begin
            errors++;
            $display("FAIL drop_at_last: got dropped=%b last=%b, expected 1 1", Dropped, bus.RvviAxiWlast);
        end
        tick();
        Send = 1'b0;
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL done_after_last: got %b, expected 1", Done);
        end
        repeat (IFG) tick();
        checks++;
        if (Busy !== 1'b0 || bus.RvviAxiWvalid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drop_ignored: got busy=%b valid=%b left=%0d, expected 0 0 0",
                     Busy, bus.RvviAxiWvalid, exp_q.size());
        end
    endtask

    task automatic test_snapshot();
        bit seen;
        DstMac  = 48'h0A0B_0C0D_0E0F;
        SrcMac  = 48'h1011_1213_1415;
        EthType = 16'h88B5;
        Minstr  = 64'h7766_5544_3322_1100;
        Ipd     = 32'h1357_9BDF;
        Send = 1'b1;
        push_frame();
        tick();
        Send    = 1'b0;
        Minstr  = 64'h1;
        Ipd     = 32'h0;
        DstMac  = '0;
        SrcMac  = '1;
        EthType = 16'h0;
        wait_done(40, seen);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL snapshot_frame: got done=%b left=%0d, expected done=1 left=0", seen, exp_q.size());
        end
        repeat (IFG + 1) tick();
    endtask

    task automatic test_reset_midframe();
        bit seen;
        int hs0;
        Minstr = 64'h0000_0000_0000_ABCD;
        Ipd    = 32'h0000_0005;
        hs0  = hs_count;
        Send = 1'b1;
        push_frame();
        tick();
        Send = 1'b0;
        for (int c = 0; c < 40 && hs_count - hs0 < 5; c++) tick();
        checks++;
        if (hs_count - hs0 != 5) begin
            errors++;
            $display("FAIL reach_beat5: got %0d handshakes, expected 5", hs_count - hs0);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.RvviAxiWvalid !== 1'b0 || bus.RvviAxiWlast !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: got valid=%b last=%b done=%b busy=%b, expected 0 0 0 0",
                     bus.RvviAxiWvalid, bus.RvviAxiWlast, Done, Busy);
        end
        reset = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (Done !== 1'b0 || bus.RvviAxiWvalid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet: got done=%b valid=%b, expected 0 0", Done, bus.RvviAxiWvalid);
            end
        end
        hs0  = hs_count;
        Send = 1'b1;
        push_frame();
        tick();
        Send = 1'b0;
        wait_done(40, seen);
        checks++;
        if (!seen || hs_count - hs0 != FW || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_frame: got done=%b handshakes=%0d left=%0d, expected done=1 handshakes=%0d left=0",
                     seen, hs_count - hs0, exp_q.size(), FW);
        end
        repeat (IFG + 1) tick();
    endtask

    initial begin
        reset   = 1'b1;
        Send    = 1'b0;
        Minstr  = '0;
        Ipd     = '0;
        DstMac  = '0;
        SrcMac  = '0;
        EthType = '0;
        bus.RvviAxiWready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_snapshot();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
